// File: rtl/rst_sequencer.sv
// Power-on / push-button reset sequencer: waits for PLL lock, holds reset for a fixed
// number of cycles, and re-enters the sequence on lock loss or a debounced button press.
module rst_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned HOLD_CYCLES     = 32
) (
    input  logic       clk,
    input  logic       reset_ni,
    input  logic       locked_i,
    input  logic       btn_i,
    output logic       reset_o,
    output logic       btn_o,
    output logic [1:0] state_o,
    output logic [7:0] lock_loss_o
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'b00,
        StHold     = 2'b01,
        StRun      = 2'b10
    } state_e;

    logic             lock_meta_q, lock_s_q;
    logic             btn_meta_q, btn_s_q;
    logic             btn_q, btn_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    state_e           state_q, state_d;
    logic [7:0]       lock_loss_q, lock_loss_d;
    logic             lost;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_q       <= 1'b0;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            state_q     <= StWaitLock;
            lock_loss_q <= 8'd0;
        end else begin
            lock_meta_q <= locked_i;
            lock_s_q    <= lock_meta_q;
            btn_meta_q  <= btn_i;
            btn_s_q     <= btn_meta_q;
            btn_q       <= btn_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            lock_loss_q <= lock_loss_d;
        end
    end

    // Debounce: any return to the accepted level restarts the count.
    always_comb begin
        btn_d    = btn_q;
        db_cnt_d = db_cnt_q;
        if (btn_s_q == btn_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            btn_d    = btn_s_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lost       = 1'b0;
        case (state_q)
            StWaitLock: begin
                hold_cnt_d = '0;
                if (lock_s_q) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!lock_s_q) begin
                    state_d    = StWaitLock;
                    hold_cnt_d = '0;
                    lost       = 1'b1;
                end else if (btn_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                hold_cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                    lost    = 1'b1;
                end else if (btn_q) begin
                    state_d = StHold;
                end
            end
            default: begin
                state_d    = StWaitLock;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        lock_loss_d = lock_loss_q;
        if (lost && (lock_loss_q != 8'hFF)) begin
            lock_loss_d = lock_loss_q + 8'd1;
        end
    end

    // Decoded from the state register alone so reset_o cannot glitch.
    assign reset_o     = (state_q != StRun);
    assign state_o     = state_q;
    assign btn_o       = btn_q;
    assign lock_loss_o = lock_loss_q;

endmodule
